// File: rtl/seq_div_16x8_pkg.sv
// Shared constants for the sequential 2*DW by DW restoring divider:
// state encoding, default width and the iteration-counter width helper.
package seq_div_16x8_pkg;

    localparam int DW_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold 0..DW
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(DW_DEF + 1);

endpackage

// File: rtl/seq_div_16x8_step.sv
// One restoring-division step: shift the partial remainder left by one,
// bring in the next dividend bit, subtract the divisor when it fits.
module div_step
    import seq_div_16x8_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]   r_in,
    input  logic          d_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   r_out,
    output logic          q_bit
);

    logic [DW:0] t;
    logic [DW:0] dvs_ext;
    logic [DW:0] diff;

    always_comb begin
        t       = {r_in[DW-1:0], d_bit};
        dvs_ext = {1'b0, divisor};
        diff    = t - dvs_ext;
        // A set R MSB means the shifted value overflowed DW+1 bits, so it fits.
        q_bit   = r_in[DW] | (t >= dvs_ext);
        r_out   = q_bit ? diff : t;
    end

endmodule

// File: rtl/seq_div_16x8.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor, one
// quotient bit per cycle, with divide-by-zero and quotient-overflow flags.
module seq_div_16x8
    import seq_div_16x8_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div0,
    output logic            ovf
);

    localparam int              CNT_W = cnt_w(DW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DW - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW:0]      r_q, r_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;

    logic [DW:0]      r_nxt;
    logic             q_bit;

    // acc holds the unconsumed dividend low bits (MSB first) and collects
    // quotient bits at the LSB as they are produced.
    div_step #(.DW(DW)) u_step (
        .r_in    (r_q),
        .d_bit   (acc_q[DW-1]),
        .divisor (dvs_q),
        .r_out   (r_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = '1;
                        div0_d  = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        quo_d   = '1;
                        rem_d   = '0;
                        div0_d  = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        r_d     = {1'b0, dividend[2*DW-1:DW]};
                        acc_d   = dividend[DW-1:0];
                        dvs_d   = divisor;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                r_d   = r_nxt;
                acc_d = {acc_q[DW-2:0], q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    quo_d   = {acc_q[DW-2:0], q_bit};
                    rem_d   = r_nxt[DW-1:0];
                    div0_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div0      = div0_q;
    assign ovf       = ovf_q;

endmodule
